// File: rtl/uart_bus_poller.sv
// rtl/uart_bus_poller.sv - UART status poller bridging a byte-stream client to the uart host bus
//
// Purpose: polls the uart status register, drains received bytes into an rx
// valid/ready stream and writes bytes taken from a tx valid/ready stream to the
// uart data register, all without CPU involvement.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cs, as, rw, addr, wr_data     registered bus request (held until rdy)
//   rd_data, rdy                  bus response
//   tx_in_valid/ready/data        byte stream from client to uart
//   rx_out_valid/ready/data       byte stream from uart to client
//   bus_err                       one-cycle pulse when a transfer times out
//   rx_count, tx_count            completed data transfers (UART_POLL_STATS_EN only)
//
// Optional feature macro: UART_POLL_STATS_EN adds the rx_count/tx_count outputs.

module uart_bus_poller #(
    parameter int POLL_DIV = 64,
    parameter int TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cs,
    output logic        as,
    output logic        rw,
    output logic        addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        rdy,
    input  logic        tx_in_valid,
    output logic        tx_in_ready,
    input  logic [7:0]  tx_in_data,
    output logic        rx_out_valid,
    input  logic        rx_out_ready,
    output logic [7:0]  rx_out_data,
    output logic        bus_err
`ifdef UART_POLL_STATS_EN
    ,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count
`endif
);

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_RD,
        S_DECIDE,
        S_DATA_RD,
        S_CLR_WR,
        S_DATA_WR
    } state_t;

    state_t        state;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tx_full;
    logic [7:0]    tx_byte;
    logic          st_rx;
    logic          st_busy;

    // Only the low byte and two status bits of the read bus carry meaning.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{rd_data[31:8], rd_data[2:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            poll_cnt     <= POLL_RELOAD;
            tmo_cnt      <= '0;
            cs           <= 1'b0;
            as           <= 1'b0;
            rw           <= 1'b0;
            addr         <= 1'b0;
            wr_data      <= '0;
            tx_full      <= 1'b0;
            tx_byte      <= '0;
            tx_in_ready  <= 1'b0;
            rx_out_valid <= 1'b0;
            rx_out_data  <= '0;
            bus_err      <= 1'b0;
            st_rx        <= 1'b0;
            st_busy      <= 1'b0;
`ifdef UART_POLL_STATS_EN
            rx_count     <= '0;
            tx_count     <= '0;
`endif
        end else begin
            bus_err     <= 1'b0;
            tx_in_ready <= ~tx_full;

            // Accept only while ready, which implies tx_full=0, so this can
            // never coincide with the DATA_WR completion that clears tx_full.
            if (tx_in_valid && tx_in_ready) begin
                tx_full     <= 1'b1;
                tx_byte     <= tx_in_data;
                tx_in_ready <= 1'b0;
            end

            if (rx_out_valid && rx_out_ready) begin
                rx_out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (tx_full || poll_cnt == '0) begin
                        poll_cnt <= POLL_RELOAD;
                        state    <= S_ST_RD;
                    end else begin
                        poll_cnt <= poll_cnt - PW'(1);
                    end
                end

                S_DECIDE: begin
                    if (st_rx && !rx_out_valid) begin
                        state <= S_DATA_RD;
                    end else if (tx_full && !st_busy) begin
                        state <= S_DATA_WR;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                // Every bus state enters with cs=0 (the previous transfer
                // dropped it), spends that cycle launching the request, then
                // waits for rdy. This guarantees the idle gap between transfers.
                S_ST_RD, S_DATA_RD, S_CLR_WR, S_DATA_WR: begin
                    if (!cs) begin
                        cs      <= 1'b1;
                        as      <= 1'b1;
                        rw      <= (state == S_CLR_WR) || (state == S_DATA_WR);
                        addr    <= (state == S_DATA_RD) || (state == S_DATA_WR);
                        wr_data <= (state == S_DATA_WR) ? {24'b0, tx_byte} : 32'b0;
                        tmo_cnt <= '0;
                    end else if (rdy) begin
                        cs <= 1'b0;
                        as <= 1'b0;
                        if (state == S_ST_RD) begin
                            st_rx   <= rd_data[0];
                            st_busy <= rd_data[3];
                            state   <= S_DECIDE;
                        end else if (state == S_DATA_RD) begin
                            rx_out_data  <= rd_data[7:0];
                            rx_out_valid <= 1'b1;
                            state        <= S_CLR_WR;
`ifdef UART_POLL_STATS_EN
                            rx_count     <= rx_count + 16'd1;
`endif
                        end else if (state == S_CLR_WR) begin
                            state <= (tx_full && !st_busy) ? S_DATA_WR : S_IDLE;
                        end else begin
                            tx_full     <= 1'b0;
                            tx_in_ready <= 1'b1;
                            state       <= S_IDLE;
`ifdef UART_POLL_STATS_EN
                            tx_count    <= tx_count + 16'd1;
`endif
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort; held bytes stay put so a pending tx is retried.
                        cs      <= 1'b0;
                        as      <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_poller.sv
// tb/tb_uart_bus_poller.sv - directed self-checking bench for uart_bus_poller
module tb_uart_bus_poller;

    localparam int POLL_DIV = 4;
    localparam int TIMEOUT  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs, as, rw, addr, bus_err;
    logic [31:0] wr_data;
    logic [31:0] rd_data = '0;
    logic        rdy = 1'b0;
    logic        tx_in_valid = 1'b0;
    logic        tx_in_ready;
    logic [7:0]  tx_in_data = '0;
    logic        rx_out_valid;
    logic        rx_out_ready = 1'b1;
    logic [7:0]  rx_out_data;
`ifdef UART_POLL_STATS_EN
    logic [15:0] rx_count, tx_count;
`endif

    uart_bus_poller #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cs(cs), .as(as), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy(rdy),
        .tx_in_valid(tx_in_valid), .tx_in_ready(tx_in_ready), .tx_in_data(tx_in_data),
        .rx_out_valid(rx_out_valid), .rx_out_ready(rx_out_ready), .rx_out_data(rx_out_data),
        .bus_err(bus_err)
`ifdef UART_POLL_STATS_EN
        , .rx_count(rx_count), .tx_count(tx_count)
`endif
    );

    always #5 clk = ~clk;

    // Slave model controls (written by the stimulus block only)
    int         lat = 0;
    bit         no_rdy = 1'b0;
    bit         rx_pend = 1'b0;
    int         arm_at = 0;
    int         busy_until = 0;
    logic [7:0] data_val = '0;

    // Monitor state (written by the monitor only)
    int          clr_writes = 0;
    int          status_reads = 0;
    logic        log_rw   [256];
    logic        log_addr [256];
    logic [31:0] log_wd   [256];
    int          n_log = 0;
    int          cyc = 0;
    bit          cs_q = 1'b0;
    int          rise_cyc [256];
    int          n_rise = 0;
    bit          prev_ack = 1'b0;
    int          gap_err = 0;
    int          streak = 0;
    int          last_streak = 0;
    int          err_cycles = 0;
    int          rxv_cycles = 0;
    logic [7:0]  rx_seen = '0;

    int wcnt = 0;
    int n_assert = 0;
    int n_fail = 0;

    // Slave: irq_rx stays set until a status-clear write follows the arming;
    // tx_busy reads as set until the given number of status reads completes.
    always @(negedge clk) begin
        if (cs && as && !no_rdy) begin
            if (wcnt >= lat) begin
                rdy = 1'b1;
                rd_data = addr ? {24'b0, data_val}
                               : {28'b0, (status_reads < busy_until), 2'b00,
                                  (rx_pend && clr_writes == arm_at)};
            end else begin
                rdy = 1'b0;
                wcnt++;
            end
        end else begin
            rdy = 1'b0;
            wcnt = 0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (cs && as && rdy) begin
            log_rw[n_log % 256]   = rw;
            log_addr[n_log % 256] = addr;
            log_wd[n_log % 256]   = wr_data;
            n_log++;
            if (!rw && !addr) status_reads++;
            if (rw && !addr) clr_writes++;
        end
        if (prev_ack && cs) gap_err++;
        prev_ack = cs && as && rdy;
        if (cs && !cs_q) begin
            rise_cyc[n_rise % 256] = cyc;
            n_rise++;
        end
        cs_q = cs;
        if (cs && as) streak++;
        else begin
            if (streak > 0) last_streak = streak;
            streak = 0;
        end
        if (bus_err) err_cycles++;
        if (rx_out_valid) begin
            rxv_cycles++;
            rx_seen = rx_out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_acc(input int from, input logic r, input logic a);
        int n = 0;
        for (int i = from; i < n_log; i++)
            if (log_rw[i % 256] == r && log_addr[i % 256] == a) n++;
        return n;
    endfunction

    function automatic int find_acc(input int from, input logic r, input logic a);
        for (int i = from; i < n_log; i++)
            if (log_rw[i % 256] == r && log_addr[i % 256] == a) return i;
        return -1;
    endfunction

    task automatic send_tx(input logic [7:0] d);
        chk("tx_ready_before_send", {31'b0, tx_in_ready}, 32'd1);
        tx_in_valid = 1'b1;
        tx_in_data  = d;
        @(negedge clk);
        tx_in_valid = 1'b0;
        chk("tx_ready_after_accept", {31'b0, tx_in_ready}, 32'd0);
    endtask

    initial begin
        int base, k, c0, e0, sr0, rb;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'b0, cs}, 32'd0);
        chk("rst_as", {31'b0, as}, 32'd0);
        chk("rst_rw_addr", {30'b0, rw, addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_tx_ready", {31'b0, tx_in_ready}, 32'd0);
        chk("rst_rx_valid", {31'b0, rx_out_valid}, 32'd0);
        chk("rst_rx_data", {24'b0, rx_out_data}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tx_ready", {31'b0, tx_in_ready}, 32'd1);

        // Idle polling: status=0 -> status read every POLL_DIV+3 cycles
        base = n_log;
        rb = n_rise;
        repeat (40) @(negedge clk);
        chk("idle_poll_count_ge3", {31'b0, (n_rise - rb) >= 3}, 32'd1);
        for (int i = rb + 1; i < n_rise; i++)
            chk("idle_poll_period", rise_cyc[i % 256] - rise_cyc[(i - 1) % 256], POLL_DIV + 3);
        chk("idle_no_data_rd", count_acc(base, 1'b0, 1'b1), 32'd0);
        chk("idle_no_writes", count_acc(base, 1'b1, 1'b0) + count_acc(base, 1'b1, 1'b1), 32'd0);
        chk("idle_gap", gap_err, 32'd0);

        // rx path with consumer ready
        base = n_log;
        c0 = clr_writes;
        e0 = rxv_cycles;
        data_val = 8'h5A;
        arm_at = clr_writes;
        rx_pend = 1'b1;
        for (int i = 0; i < 60 && clr_writes == c0; i++) @(negedge clk);
        chk("rx_clr_write_seen", {31'b0, clr_writes != c0}, 32'd1);
        k = find_acc(base, 1'b0, 1'b1);
        chk("rx_data_read_seen", {31'b0, k >= 1}, 32'd1);
        if (k >= 1) begin
            chk("rx_before_is_status_rd", {30'b0, log_rw[(k - 1) % 256], log_addr[(k - 1) % 256]}, 32'd0);
            chk("rx_after_is_clr_wr", {30'b0, log_rw[(k + 1) % 256], log_addr[(k + 1) % 256]}, 32'd2);
            chk("rx_clr_wr_data", log_wd[(k + 1) % 256], 32'd0);
        end
        repeat (5) @(negedge clk);
        chk("rx_valid_one_cycle", rxv_cycles - e0, 32'd1);
        chk("rx_data_5a", {24'b0, rx_seen}, 32'h5A);
        chk("rx_gap", gap_err, 32'd0);

        // tx path with busy for 3 polls
        busy_until = status_reads + 3;
        base = n_log;
        send_tx(8'hA5);
        for (int i = 0; i < 80 && count_acc(base, 1'b1, 1'b1) == 0; i++) @(negedge clk);
        k = find_acc(base, 1'b1, 1'b1);
        chk("tx_write_seen", {31'b0, k >= 0}, 32'd1);
        if (k >= 0) begin
            chk("tx_status_reads_before_wr", count_acc(base, 1'b0, 1'b0), 32'd4);
            chk("tx_write_data", log_wd[k % 256], 32'h0000_00A5);
        end
        chk("tx_write_once", count_acc(base, 1'b1, 1'b1), 32'd1);
        chk("tx_ready_restored", {31'b0, tx_in_ready}, 32'd1);

        // rx back-pressure: held byte blocks DATA_RD
        rx_out_ready = 1'b0;
        c0 = clr_writes;
        data_val = 8'h11;
        arm_at = clr_writes;
        for (int i = 0; i < 60 && clr_writes == c0; i++) @(negedge clk);
        chk("bp_first_byte_valid", {31'b0, rx_out_valid}, 32'd1);
        chk("bp_first_byte", {24'b0, rx_out_data}, 32'h11);
        data_val = 8'h22;
        arm_at = clr_writes;
        base = n_log;
        sr0 = status_reads;
        repeat (30) @(negedge clk);
        chk("bp_no_data_rd", count_acc(base, 1'b0, 1'b1), 32'd0);
        chk("bp_polling_continues", {31'b0, (status_reads - sr0) >= 3}, 32'd1);
        chk("bp_byte_held", {24'b0, rx_out_data}, 32'h11);
        rx_out_ready = 1'b1;
        @(negedge clk);
        rx_out_ready = 1'b0;
        chk("bp_consumed", {31'b0, rx_out_valid}, 32'd0);
        for (int i = 0; i < 40 && !rx_out_valid; i++) @(negedge clk);
        chk("bp_second_valid", {31'b0, rx_out_valid}, 32'd1);
        chk("bp_second_byte", {24'b0, rx_out_data}, 32'h22);
        rx_out_ready = 1'b1;
        c0 = clr_writes;
        for (int i = 0; i < 20 && clr_writes == c0; i++) @(negedge clk);
        repeat (3) @(negedge clk);

        // Timeout with a pending tx byte, then retry
        no_rdy = 1'b1;
        e0 = err_cycles;
        base = n_log;
        send_tx(8'h3C);
        for (int i = 0; i < 40 && !bus_err; i++) @(negedge clk);
        chk("tmo_bus_err_seen", {31'b0, bus_err}, 32'd1);
        repeat (2) @(negedge clk);
        chk("tmo_cs_held_cycles", last_streak, TIMEOUT);
        chk("tmo_bus_err_width", err_cycles - e0, 32'd1);
        chk("tmo_tx_retained", {31'b0, tx_in_ready}, 32'd0);
        chk("tmo_no_write", count_acc(base, 1'b1, 1'b1), 32'd0);
        no_rdy = 1'b0;
        for (int i = 0; i < 40 && count_acc(base, 1'b1, 1'b1) == 0; i++) @(negedge clk);
        k = find_acc(base, 1'b1, 1'b1);
        chk("tmo_retry_seen", {31'b0, k >= 0}, 32'd1);
        if (k >= 0) chk("tmo_retry_data", log_wd[k % 256], 32'h0000_003C);
        chk("tmo_tx_ready_back", {31'b0, tx_in_ready}, 32'd1);

        // Reset in the middle of DATA_WR with an rx byte held
        rx_out_ready = 1'b0;
        lat = 2;
        data_val = 8'h99;
        arm_at = clr_writes;
        send_tx(8'h77);
        for (int i = 0; i < 80 && !(cs && as && rw && addr); i++) @(negedge clk);
        chk("mid_wr_reached", {31'b0, cs && as && rw && addr}, 32'd1);
        chk("mid_wr_rx_held", {31'b0, rx_out_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs", {31'b0, cs}, 32'd0);
        chk("mid_rst_as", {31'b0, as}, 32'd0);
        chk("mid_rst_rx_valid", {31'b0, rx_out_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_ready", {31'b0, tx_in_ready}, 32'd1);
        chk("mid_rst_rx_valid_after", {31'b0, rx_out_valid}, 32'd0);
        chk("final_gap", gap_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
